// File: rtl/cpu_defs.sv
// cpu_defs: shared datapath constants and divider state encodings
package cpu_defs;
  localparam int XLEN = 32;
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIN  = 2'd2;
  localparam logic DIV_ZERO_BIT = 1'b1;
endpackage

// File: rtl/sub_lookahead_nbits.sv
// sub_lookahead_nbits: N-bit subtractor from 4-bit borrow-lookahead slices
module sub_lookahead_nbits #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);
  logic [N/4:0] bc;
  assign bc[0] = 1'b0;
  for (genvar s = 0; s < N/4; s++) begin : g_s
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = ~a[4*s +: 4] & b[4*s +: 4];
    assign p = ~(a[4*s +: 4] ^ b[4*s +: 4]);
    assign c[0] = bc[s];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p & c[0]);
    assign diff[4*s +: 4] = a[4*s +: 4] ^ b[4*s +: 4] ^ c[3:0];
    assign bc[s+1] = c[4];
  end
  assign borrow_out = bc[N/4];
endmodule

// File: rtl/div_restoring_seq.sv
// div_restoring_seq: multi-cycle restoring divider, one quotient bit per clock
module div_restoring_seq import cpu_defs::*; #(parameter int WIDTH = XLEN) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state;
  logic [CW-1:0] count;
  logic [WIDTH:0] r, shifted, r_n;
  logic [WIDTH-1:0] q, d, q_n, diff, rem_mag;
  logic qneg, rneg, bo, nb;
  assign busy = state != DIV_IDLE;
  assign done = state == DIV_FIN;
  assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};
  sub_lookahead_nbits #(.N(WIDTH)) u_sub (
    .a(shifted[WIDTH-1:0]),
    .b(d),
    .diff(diff),
    .borrow_out(bo)
  );
  // a set bit above the subtractor width means the trial cannot borrow
  assign nb = shifted[WIDTH] | r[WIDTH] | ~bo;
  assign r_n = nb ? {1'b0, diff} : shifted;
  assign q_n = {q[WIDTH-2:0], nb};
  assign rem_mag = r_n[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      count <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          d <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
          q <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          r <= '0;
          count <= CW'(WIDTH-1);
          qneg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg <= is_signed & dividend[WIDTH-1];
          if (divisor == '0) begin
            quotient <= {WIDTH{DIV_ZERO_BIT}};
            remainder <= dividend;
            div_zero <= 1'b1;
            state <= DIV_FIN;
          end else
            state <= DIV_CALC;
        end
        DIV_CALC: begin
          r <= r_n;
          q <= q_n;
          count <= count - 1'b1;
          if (count == '0) begin
            quotient <= qneg ? -q_n : q_n;
            remainder <= rneg ? -rem_mag : rem_mag;
            div_zero <= 1'b0;
            state <= DIV_FIN;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_restoring_seq.sv
// tb_div_restoring_seq: table, corner-sequence and random checks of div_restoring_seq
module tb_div_restoring_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, done, div_zero;
  logic [31:0] quotient, remainder;
  int vectors = 0, miscompares = 0;

  div_restoring_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s;
    logic [31:0] a, b, eq, er;
    logic edz;
    int elat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: plain arithmetic from the divide rules
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er, output logic edz, output int elat);
    edz = 1'b0;
    elat = 33;
    if (b == 0) begin
      eq = 32'hFFFF_FFFF; er = a; edz = 1'b1; elat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      eq = 32'h8000_0000; er = 0;
    end else if (s) begin
      eq = $signed(a) / $signed(b); er = $signed(a) % $signed(b);
    end else begin
      eq = a / b; er = a % b;
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] qq, output logic [31:0] rr, output logic dz, output int lat);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    qq = quotient; rr = remainder; dz = div_zero;
  endtask

  initial begin
    vec_t tbl[9];
    logic [31:0] qq, rr, eq, er;
    logic dz, edz;
    int lat, elat, n, pulses;
    tbl[0] = '{0, 100, 7, 14, 2, 0, 33};
    tbl[1] = '{1, -32'sd7, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33};
    tbl[2] = '{1, 7, -32'sd2, -32'sd3, 1, 0, 33};
    tbl[3] = '{0, 32'h1234, 0, 32'hFFFF_FFFF, 32'h1234, 1, 1};
    tbl[4] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 33};
    tbl[5] = '{0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, 33};
    tbl[6] = '{1, 32'hFFFF_FF00, 0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1, 1};
    tbl[7] = '{0, 5, 9, 0, 5, 0, 33};
    tbl[8] = '{1, -32'sd100, -32'sd7, 14, 32'hFFFF_FFFE, 0, 33};
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_zero", {31'b0, div_zero}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run(tbl[i].s, tbl[i].a, tbl[i].b, qq, rr, dz, lat);
      chk($sformatf("tbl%0d quotient", i), qq, tbl[i].eq);
      chk($sformatf("tbl%0d remainder", i), rr, tbl[i].er);
      chk($sformatf("tbl%0d div_zero", i), {31'b0, dz}, {31'b0, tbl[i].edz});
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].elat));
    end
    // start held through busy and FIN, then a back-to-back start after done
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 100; divisor = 7;
    @(negedge clk);
    chk("hold busy cycle1", {31'b0, busy}, 1);
    dividend = 50; divisor = 5;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold quotient", quotient, 14);
    chk("hold remainder", remainder, 2);
    chk("hold latency", 32'(n), 33);
    @(negedge clk);
    chk("after done busy", {31'b0, busy}, 0);
    dividend = 1000; divisor = 10;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b quotient", quotient, 100);
    chk("b2b remainder", remainder, 0);
    chk("b2b latency", 32'(n), 33);
    // reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; dividend = 32'h1234_5678; divisor = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_zero", {31'b0, div_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort done pulses", 32'(pulses), 0);
    run(0, 9, 3, qq, rr, dz, lat);
    chk("post-reset quotient", qq, 3);
    chk("post-reset remainder", rr, 0);
    // random operands against the reference
    for (int i = 0; i < 200; i++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: b = {16'h0, 16'($urandom)};
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      ref_div(s, a, b, eq, er, edz, elat);
      run(s, a, b, qq, rr, dz, lat);
      chk($sformatf("rnd%0d quotient", i), qq, eq);
      chk($sformatf("rnd%0d remainder", i), rr, er);
      chk($sformatf("rnd%0d div_zero", i), {31'b0, dz}, {31'b0, edz});
      chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(elat));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
